// File: rtl/bit_insert_if.sv
// Request/response bundle for the bit-field insert unit.
// The master issues operands; the slave returns stall, ready, result and err.
interface bit_insert_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [4:0]       pos;
  logic             stall;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, flush, rs_data, rt_data, pos,
    input  stall, ready, result, err
  );

  modport slave (
    input  start, flush, rs_data, rt_data, pos,
    output stall, ready, result, err
  );
endinterface

// File: rtl/bit_insert.sv
// Serial bit-field insert: writes a FIELD-bit byte into rt_data at offset pos,
// shifting the field and its mask one bit per cycle while the pipeline stalls.
module bit_insert #(
  parameter int WIDTH   = 32,
  parameter int FIELD   = 8,
  parameter int MAX_POS = WIDTH - FIELD
) (
  input  logic          clk,
  input  logic          rst,
  bit_insert_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] FIELD_MASK = {{(WIDTH-FIELD){1'b0}}, {FIELD{1'b1}}};

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rt_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             stall;
  logic             ready;
  logic             accept;
  logic             pos_bad;

  assign accept  = (state == IDLE) && bus.start && !bus.flush;
  assign pos_bad = int'(bus.pos) > MAX_POS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = pos_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Masking rs_data (rather than slicing) zero-extends the field in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      mask_q   <= '0;
      rt_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= bus.rs_data & FIELD_MASK;
            mask_q <= FIELD_MASK;
            rt_q   <= bus.rt_data;
            cnt    <= bus.pos;
            if (pos_bad) begin
              result_q <= bus.rt_data;
              err_q    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!bus.flush) begin
            if (cnt != '0) begin
              data_q <= data_q << 1;
              mask_q <= mask_q << 1;
              cnt    <= cnt - 5'd1;
            end else begin
              result_q <= (rt_q & ~mask_q) | data_q;
              err_q    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall  = stall;
  assign bus.ready  = ready;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule
